// File: rtl/async_fifo_burst_reader.sv
// async_fifo_burst_reader: drains a show-ahead async FIFO into sop/eop-framed bursts on a valid/ready stream,
// flushing partial bursts after an idle timeout; a 2-entry skid buffer isolates fifo_rdreq from m_ready.
module async_fifo_burst_reader #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       rdclk,
  input  logic                       reset_n,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_q,
  input  logic                       fifo_rdempty,
  input  logic [FIFO_ADDR_WIDTH-1:0] fifo_rdusedw,
  output logic                       fifo_rdreq,
  output logic [FIFO_DATA_WIDTH-1:0] m_data,
  output logic                       m_valid,
  output logic                       m_sop,
  output logic                       m_eop,
  input  logic                       m_ready,
  output logic                       busy
);
  localparam int UW = FIFO_ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [UW-1:0] BL = UW'(BURST_LEN);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nxt;
  logic [UW-1:0] eff_used, rem, rem_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic first, first_nxt;
  logic [1:0] occ;
  logic [FIFO_DATA_WIDTH+1:0] head, tail, entry;
  logic full_hit, flush_hit, push, pop;
  // rdusedw reads 0 both when empty and when completely full
  assign eff_used = fifo_rdempty ? '0 : fifo_rdusedw == '0 ? {1'b1, {FIFO_ADDR_WIDTH{1'b0}}} : {1'b0, fifo_rdusedw};
  assign full_hit = eff_used >= BL;
  assign flush_hit = TIMEOUT != 0 && tcnt == T_LAST && !fifo_rdempty;
  assign fifo_rdreq = state == BURST && rem != '0 && !fifo_rdempty && occ != 2'd2;
  assign entry = {first, rem == UW'(1), fifo_q};
  assign push = fifo_rdreq;
  assign pop = m_valid && m_ready;
  assign m_valid = occ != 2'd0;
  assign m_sop = m_valid && head[FIFO_DATA_WIDTH+1];
  assign m_eop = m_valid && head[FIFO_DATA_WIDTH];
  assign m_data = head[FIFO_DATA_WIDTH-1:0];
  assign busy = state == BURST || m_valid;
  always_comb begin
    state_nxt = state;
    rem_nxt = rem;
    tcnt_nxt = '0;
    first_nxt = first;
    if (state == IDLE) begin
      tcnt_nxt = (!fifo_rdempty && !full_hit) ? tcnt + 1'b1 : '0;
      if (full_hit || flush_hit) begin
        state_nxt = BURST;
        rem_nxt = full_hit ? BL : eff_used;
        tcnt_nxt = '0;
        first_nxt = 1'b1;
      end
    end else begin
      rem_nxt = fifo_rdreq ? rem - 1'b1 : rem;
      first_nxt = first && !fifo_rdreq;
      state_nxt = rem_nxt == '0 ? IDLE : BURST;
    end
  end
  always_ff @(posedge rdclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rem <= '0;
      tcnt <= '0;
      first <= 1'b0;
      occ <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      state <= state_nxt;
      rem <= rem_nxt;
      tcnt <= tcnt_nxt;
      first <= first_nxt;
      occ <= occ + {1'b0, push} - {1'b0, pop};
      // head is always the oldest entry; tail only holds the second one
      if (pop && occ == 2'd2) head <= tail;
      else if (push && (pop || occ == 2'd0)) head <= entry;
      if (push && (pop ? occ == 2'd2 : occ == 2'd1)) tail <= entry;
    end
  end
endmodule
